// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm -- multi-cycle control sequencer for the single-datapath MIPS core.
//
// Each instruction moves through FETCH -> DECODE -> EXEC/BRANCH/JUMP ->
// MEM_RD/MEM_WR -> WB_*. The block drives the IR/PC/GPR/DM write strobes and
// the select lines of the shared ALU, DM and GPR paths. It also counts retired
// instructions.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset; forces every output to 0
//   opcode/funct IR fields, sampled in DECODE
//   zero         ALU zero flag, sampled in BRANCH
//   oflow        ALU signed overflow, sampled in EXEC (addi only)
//   ir_wr        load IR from instruction memory
//   pc_wr        load PC from npc (exactly once per instruction)
//   npc_sel      00 pc+4, 01 branch target, 10 j/jal target, 11 jr (rs)
//   reg_wr       GPR write enable
//   regdst       1 selects rd, 0 selects rt as the write register
//   link         jal: write register 31 with pc+4
//   memtoreg     1 selects DM data, 0 selects the ALU result for the write
//   mem_wr       DM write enable
//   alusrc       1 selects the extended immediate, 0 selects rt data
//   ext_sel      1 sign-extends, 0 zero-extends the immediate
//   aluop        000 add, 001 sub, 010 or, 011 slt, 100 lui
//   lb_flag      byte load
//   sb_flag      byte store
//   instr_done   one-cycle pulse on the last cycle of each instruction
//   retired_cnt  count of instr_done pulses, wraps modulo 2^CNT_W
//   state        current state, for debug
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             oflow,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             reg_wr,
  output logic             regdst,
  output logic             link,
  output logic             memtoreg,
  output logic             mem_wr,
  output logic             alusrc,
  output logic             ext_sel,
  output logic [2:0]       aluop,
  output logic             lb_flag,
  output logic             sb_flag,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ  = 6'h04, OP_ADDI = 6'h08, OP_ORI = 6'h0D,
                         OP_LUI  = 6'h0F, OP_LB  = 6'h20, OP_LW  = 6'h23,
                         OP_SB   = 6'h28, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_JR   = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                         FN_SLT  = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010,
                         ALU_SLT = 3'b011, ALU_LUI = 3'b100;

  function automatic logic is_r_alu(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_R) && (fn == FN_ADDU || fn == FN_SUBU || fn == FN_SLT);
  endfunction

  function automatic logic is_exec(input logic [5:0] op, input logic [5:0] fn);
    return is_r_alu(op, fn) || op == OP_ORI || op == OP_LUI || op == OP_ADDI ||
           op == OP_LW || op == OP_LB || op == OP_SW || op == OP_SB;
  endfunction

  function automatic logic is_jump(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_J || op == OP_JAL || (op == OP_R && fn == FN_JR);
  endfunction

  state_t           state_q;
  logic [5:0]       op_q, funct_q;
  logic             ov_q;
  logic             ir_wr_q, pc_wr_q, reg_wr_q, regdst_q, link_q, memtoreg_q;
  logic             mem_wr_q, lb_q, sb_q, done_q;
  logic [1:0]       npc_q;
  logic [CNT_W-1:0] cnt_q;

  // Input-dependent terms: an unsupported instruction retires in DECODE
  // itself, and the branch decision uses zero in the BRANCH cycle. Neither
  // can be known a cycle early, so they are merged onto the registered strobes.
  logic illegal_dec, done_c;
  assign illegal_dec = (state_q == S_DECODE) &&
                       !(is_exec(opcode, funct) || is_jump(opcode, funct) ||
                         opcode == OP_BEQ);
  assign done_c      = done_q | illegal_dec;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments, so every branch
    // sees the register values from before this edge.
    ir_wr_q    <= 1'b0;
    pc_wr_q    <= 1'b0;
    npc_q      <= 2'b00;
    reg_wr_q   <= 1'b0;
    regdst_q   <= 1'b0;
    link_q     <= 1'b0;
    memtoreg_q <= 1'b0;
    mem_wr_q   <= 1'b0;
    lb_q       <= 1'b0;
    sb_q       <= 1'b0;
    done_q     <= 1'b0;
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
      ir_wr_q <= 1'b1;  // strobe of the FETCH cycle that follows reset
    end else begin
      if (done_c) cnt_q <= cnt_q + 1'b1;
      // Each transition loads the strobes of the state being entered.
      unique case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          op_q    <= opcode;
          funct_q <= funct;
          if (is_exec(opcode, funct)) begin
            state_q <= S_EXEC;
          end else if (opcode == OP_BEQ) begin
            state_q <= S_BRANCH;
            pc_wr_q <= 1'b1;
            done_q  <= 1'b1;
          end else if (is_jump(opcode, funct)) begin
            state_q  <= S_JUMP;
            pc_wr_q  <= 1'b1;
            done_q   <= 1'b1;
            npc_q    <= (opcode == OP_R) ? 2'b11 : 2'b10;
            reg_wr_q <= (opcode == OP_JAL);
            link_q   <= (opcode == OP_JAL);
          end else begin
            state_q <= S_FETCH;
            ir_wr_q <= 1'b1;
          end
        end
        S_EXEC: begin
          ov_q <= (op_q == OP_ADDI) ? oflow : 1'b0;
          if (op_q == OP_LW || op_q == OP_LB) begin
            state_q <= S_MEM_RD;
            lb_q    <= (op_q == OP_LB);
          end else if (op_q == OP_SW || op_q == OP_SB) begin
            state_q  <= S_MEM_WR;
            mem_wr_q <= 1'b1;
            sb_q     <= (op_q == OP_SB);
            pc_wr_q  <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            state_q  <= S_WB_ALU;
            reg_wr_q <= 1'b1;  // suppressed on addi overflow via ov_q
            regdst_q <= (op_q == OP_R);
            pc_wr_q  <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        S_MEM_RD: begin
          state_q    <= S_WB_MEM;
          reg_wr_q   <= 1'b1;
          memtoreg_q <= 1'b1;
          lb_q       <= (op_q == OP_LB);
          pc_wr_q    <= 1'b1;
          done_q     <= 1'b1;
        end
        default: begin
          state_q <= S_FETCH;
          ir_wr_q <= 1'b1;
        end
      endcase
    end
  end

  // ALU selects decode from the latched instruction, so they hold their EXEC
  // values through the MEM and WB states without extra registers.
  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    aluop   = ALU_ADD;
    alusrc  = 1'b0;
    ext_sel = 1'b0;
    if (!rst) begin
      case (state_q)
        S_EXEC, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM: begin
          case (op_q)
            OP_R: begin
              if (funct_q == FN_SUBU)     aluop = ALU_SUB;
              else if (funct_q == FN_SLT) aluop = ALU_SLT;
            end
            OP_ORI: begin
              aluop  = ALU_OR;
              alusrc = 1'b1;
            end
            OP_LUI: begin
              aluop  = ALU_LUI;
              alusrc = 1'b1;
            end
            default: begin  // addi and all loads/stores: signed add
              alusrc  = 1'b1;
              ext_sel = 1'b1;
            end
          endcase
        end
        S_BRANCH: aluop = ALU_SUB;
        default: ;
      endcase
    end
  end

  // Reset blanks every output immediately, which also kills any write strobe
  // of an instruction caught mid-flight.
  assign ir_wr       = ~rst & ir_wr_q;
  assign pc_wr       = ~rst & (pc_wr_q | illegal_dec);
  assign npc_sel     = rst ? 2'b00 : (npc_q | {1'b0, (state_q == S_BRANCH) & zero});
  assign reg_wr      = ~rst & reg_wr_q & ~((state_q == S_WB_ALU) & ov_q);
  assign regdst      = ~rst & regdst_q;
  assign link        = ~rst & link_q;
  assign memtoreg    = ~rst & memtoreg_q;
  assign mem_wr      = ~rst & mem_wr_q;
  assign lb_flag     = ~rst & lb_q;
  assign sb_flag     = ~rst & sb_q;
  assign instr_done  = ~rst & done_c;
  assign retired_cnt = rst ? '0 : cnt_q;
  assign state       = rst ? 4'd0 : state_q;

endmodule
